// File: rtl/ps2_key_decoder.sv
//==============================================================================
// Module   : ps2_key_decoder
// Purpose  : Scan-code set 2 make/break decoder for the Icy Tower controls.
//            Optional macro PS2_PREFIX_TIMEOUT_EN abandons stale E0/F0 prefixes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       new_event,
  output logic       left_held,
  output logic       right_held,
  output logic       jump_held,
  output logic       move_left,
  output logic       move_right,
  output logic       jump_pulse,
  output logic       enter_pulse,
  output logic       esc_pulse,
  output logic [7:0] last_code
);

  localparam logic [7:0] c_ext   = 8'hE0;
  localparam logic [7:0] c_brk   = 8'hF0;
  localparam logic [7:0] c_bat   = 8'hAA;
  localparam logic [7:0] c_err0  = 8'h00;
  localparam logic [7:0] c_errf  = 8'hFF;
  localparam logic [7:0] c_left  = 8'h6B;
  localparam logic [7:0] c_right = 8'h74;
  localparam logic [7:0] c_up    = 8'h75;
  localparam logic [7:0] c_space = 8'h29;
  localparam logic [7:0] c_enter = 8'h5A;
  localparam logic [7:0] c_esc   = 8'h76;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    P_NONE  = 2'd0,
    P_LEFT  = 2'd1,
    P_RIGHT = 2'd2
  } prio_t;

  state_t     state_q, state_d;
  prio_t      prio_q, prio_d;
  logic       left_q, left_d, right_q, right_d, up_q, up_d;
  logic       space_q, space_d, enter_q, enter_d, esc_q, esc_d;
  logic       move_left_q, move_left_d, move_right_q, move_right_d;
  logic       jump_held_q, jump_held_d;
  logic       jump_pulse_q, jump_pulse_d, enter_pulse_q, enter_pulse_d;
  logic       esc_pulse_q, esc_pulse_d;
  logic [7:0] last_code_q, last_code_d;

  logic w_make, w_break, w_ext, w_resync, w_timeout, w_key_evt;

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  assign w_timeout = (state_q != S_IDLE) && (tcnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    tcnt_d = '0;
    if ((state_q != S_IDLE) && !new_event && !w_timeout) begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Prefix tracking: classify each final byte as make/break, plain/extended.
  always_comb begin
    state_d  = state_q;
    w_make   = 1'b0;
    w_break  = 1'b0;
    w_ext    = 1'b0;
    w_resync = 1'b0;
    if (new_event) begin
      case (state_q)
        S_IDLE: begin
          if (key == c_ext)      state_d = S_EXT;
          else if (key == c_brk) state_d = S_BRK;
          else if (key == c_bat || key == c_err0 || key == c_errf) w_resync = 1'b1;
          else                   w_make = 1'b1;
        end
        S_EXT: begin
          if (key == c_brk)      state_d = S_EXT_BRK;
          else if (key == c_ext) state_d = S_EXT;
          else begin
            w_make  = 1'b1;
            w_ext   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (key == c_ext)      state_d = S_EXT;
          else if (key == c_brk) state_d = S_BRK;
          else begin
            w_break = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (key == c_ext)      state_d = S_EXT;
          else if (key == c_brk) state_d = S_BRK;
          else begin
            w_break = 1'b1;
            w_ext   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (w_timeout) begin
      state_d = S_IDLE;
    end
  end

  assign w_key_evt = w_make | w_break;

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    up_d    = up_q;
    space_d = space_q;
    enter_d = enter_q;
    esc_d   = esc_q;
    prio_d  = prio_q;
    if (w_resync) begin
      left_d  = 1'b0;
      right_d = 1'b0;
      up_d    = 1'b0;
      space_d = 1'b0;
      enter_d = 1'b0;
      esc_d   = 1'b0;
      prio_d  = P_NONE;
    end else if (w_key_evt) begin
      if (w_ext) begin
        if (key == c_left)  left_d  = w_make;
        if (key == c_right) right_d = w_make;
        if (key == c_up)    up_d    = w_make;
      end else begin
        if (key == c_space) space_d = w_make;
        if (key == c_enter) enter_d = w_make;
        if (key == c_esc)   esc_d   = w_make;
      end
      // Only a fresh press claims priority; releasing hands it to the other side.
      if (left_d && !left_q)   prio_d = P_LEFT;
      if (right_d && !right_q) prio_d = P_RIGHT;
      if (!left_d && left_q)   prio_d = right_q ? P_RIGHT : P_NONE;
      if (!right_d && right_q) prio_d = left_q ? P_LEFT : P_NONE;
    end
  end

  always_comb begin
    move_left_d   = left_d && (!right_d || prio_d == P_LEFT);
    move_right_d  = right_d && (!left_d || prio_d == P_RIGHT);
    jump_held_d   = space_d | up_d;
    jump_pulse_d  = (space_d & ~space_q) | (up_d & ~up_q);
    enter_pulse_d = enter_d & ~enter_q;
    esc_pulse_d   = esc_d & ~esc_q;
    last_code_d   = new_event ? key : last_code_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      prio_q        <= P_NONE;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      up_q          <= 1'b0;
      space_q       <= 1'b0;
      enter_q       <= 1'b0;
      esc_q         <= 1'b0;
      move_left_q   <= 1'b0;
      move_right_q  <= 1'b0;
      jump_held_q   <= 1'b0;
      jump_pulse_q  <= 1'b0;
      enter_pulse_q <= 1'b0;
      esc_pulse_q   <= 1'b0;
      last_code_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      left_q        <= left_d;
      right_q       <= right_d;
      up_q          <= up_d;
      space_q       <= space_d;
      enter_q       <= enter_d;
      esc_q         <= esc_d;
      move_left_q   <= move_left_d;
      move_right_q  <= move_right_d;
      jump_held_q   <= jump_held_d;
      jump_pulse_q  <= jump_pulse_d;
      enter_pulse_q <= enter_pulse_d;
      esc_pulse_q   <= esc_pulse_d;
      last_code_q   <= last_code_d;
    end
  end

  assign left_held   = left_q;
  assign right_held  = right_q;
  assign jump_held   = jump_held_q;
  assign move_left   = move_left_q;
  assign move_right  = move_right_q;
  assign jump_pulse  = jump_pulse_q;
  assign enter_pulse = enter_pulse_q;
  assign esc_pulse   = esc_pulse_q;
  assign last_code   = last_code_q;

endmodule

`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes the byte stream from the PS/2 receiver (`key` byte plus a one-cycle `new_event` strobe) and decodes scan-code set 2 make/break sequences, including E0/F0 prefixes.
- Outputs per-key held state and edge pulses for the Icy Tower game controls (left, right, jump, start, pause).
- Sits between the PS/2 receiver and the game logic / 7-segment debug display.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, clk cycles allowed between prefix byte and final byte (10 ms at 100 MHz); used only with the optional feature.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- key  input  8  received scan-code byte; valid only when new_event=1
- new_event  input  1  one-cycle strobe, one per received byte
- left_held  output  1  left arrow (E0 6B) currently pressed
- right_held  output  1  right arrow (E0 74) currently pressed
- jump_held  output  1  space (29) or up arrow (E0 75) currently pressed
- move_left  output  1  resolved horizontal command, left
- move_right  output  1  resolved horizontal command, right
- jump_pulse  output  1  one-cycle pulse on jump press
- enter_pulse  output  1  one-cycle pulse on Enter (5A) press
- esc_pulse  output  1  one-cycle pulse on Esc (76) press
- last_code  output  8  last byte received, for the hex display

Behaviour:
- Async reset: all outputs 0, FSM in IDLE, all held flags 0, priority register = none.
- All registers update on the rising edge of clk.
- Outputs are registered: held flags and pulses update one clk after the new_event of the final byte of a sequence.
- last_code loads `key` on every new_event, in every state.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE transitions:
  - E0 -> EXT
  - F0 -> BRK
  - any other byte -> non-extended make, stay in IDLE
- EXT transitions:
  - F0 -> EXT_BRK
  - E0 -> stay in EXT
  - any other byte -> extended make, go to IDLE
- BRK transitions:
  - E0 -> EXT (resync)
  - F0 -> stay in BRK
  - any other byte -> non-extended break, go to IDLE
- EXT_BRK transitions:
  - E0 -> EXT
  - F0 -> BRK
  - any other byte -> extended break, go to IDLE
- Extended flag matters: non-extended 6B/74/75 are keypad keys and must not set any held flag.
- Unmapped codes, including the E1 pause sequence, only update last_code.
- Make of a mapped key sets its held flag.
- Break of a mapped key clears its held flag.
- jump_held = space_held OR up_held, using two internal flags.
- Pulses fire only on a 0->1 transition of the key's own flag; typematic repeat makes do not pulse.
- jump_pulse fires if either space or up goes 0->1, even when the other is already held.
- Horizontal priority (last pressed wins):
  - Only left held -> move_left=1.
  - Only right held -> move_right=1.
  - Both held -> the most recently pressed direction wins.
  - Releasing the winner hands control to the other direction immediately.
  - Neither held -> both commands 0.
  - move_left and move_right are never both 1.
- Resync bytes AA (BAT complete), 00 and FF (overrun/error), received in IDLE: clear all held flags and the priority register, emit no pulses, stay in IDLE.
- The same bytes received after a prefix are treated as ordinary codes.
- A break for a key not held is a no-op.
- A make for an already-held key is a no-op apart from last_code.
- Reset asserted mid-sequence: everything clears; the next byte is decoded from IDLE.

Optional Feature:
- Macro PS2_PREFIX_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter runs while the FSM is in EXT, BRK or EXT_BRK, and clears on each new_event.
  - On reaching TIMEOUT_CYCLES the FSM returns to IDLE; no held flags change.
- Not defined:
  - No counter is built.
  - The FSM waits indefinitely in prefix states.

Test Plan:
- Reset, then bytes 29, 29, 29 with 100-cycle gaps -> jump_held=1, jump_pulse exactly once (1 clk, one cycle after the first new_event), last_code=29.
- E0 6B, E0 74, E0 F0 74 -> move_left=1 after first make; move_right=1 (move_left=0) after second; move_left=1 again after the break of right.
- Non-extended 6B, 74, 75 -> left_held, right_held and jump_held stay 0; last_code=75.
- Space held, then E0 75 -> jump_pulse fires; then F0 29 -> jump_held stays 1 until E0 F0 75.
- Left and space held, then AA -> all held flags and move outputs 0 one cycle later, no pulses; E0 F0 6B afterwards is a no-op.
- Macro defined, TIMEOUT_CYCLES=50: E0, wait 60 cycles, 6B -> treated as non-extended (left_held=0); without the macro the same stimulus sets left_held=1.
